// File: rtl/time_capture_writer.sv
// time_capture_writer: triggered capture of decimated signed 8-bit audio samples
// into the time-domain display memory (port A). One screen-width record is
// written per video frame.
// Ports:
//   ck100MHz, rstLow                    clock, async active-low reset
//   sampleValid, sampleIn               sample strobe and signed sample
//   trigLevel, trigAuto                 signed trigger threshold, auto-trigger enable
//   decim                               keep every (decim+1)-th valid sample (latched in ARM)
//   frameSync                           vertical-blank pulse used to re-arm after a record
//   enaTime, weaTime, addraTime, dinaTime  display-memory write port A
//   captureBusy, captureDone            busy while armed/capturing, pulse on final write
module time_capture_writer #(
  parameter int unsigned CAPTURE_LEN  = 640,
  parameter int unsigned AUTO_TIMEOUT = 4096
) (
  input  logic       ck100MHz,
  input  logic       rstLow,
  input  logic       sampleValid,
  input  logic [7:0] sampleIn,
  input  logic [7:0] trigLevel,
  input  logic       trigAuto,
  input  logic [3:0] decim,
  input  logic       frameSync,
  output logic       enaTime,
  output logic       weaTime,
  output logic [9:0] addraTime,
  output logic [7:0] dinaTime,
  output logic       captureBusy,
  output logic       captureDone
);

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;
  localparam int unsigned TW = $clog2(AUTO_TIMEOUT + 2);
  localparam logic [AW-1:0] LAST_ADDR = AW'(CAPTURE_LEN - 1);
  localparam logic [TW-1:0] TO_LIMIT  = TW'(AUTO_TIMEOUT);

  typedef enum logic [1:0] {
    S_ARM  = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] decim_q, decim_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [DW-1:0] prev_q, prev_d;
  logic          prev_vld_q, prev_vld_d;
  logic [TW-1:0] to_q, to_d;
  logic [AW-1:0] widx_q, widx_d;
  logic          hold_arm_q, hold_arm_d;
  logic          ena_q, ena_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          accept_c;
  logic          cross_c;
  logic          auto_c;
  logic [DW-1:0] conv_c;
  logic          wr_c;
  logic [AW-1:0] wr_idx_c;

  // Sample qualification, rising-edge trigger detection and display conversion
  assign accept_c = sampleValid && (dcnt_q == decim_q);
  assign cross_c  = prev_vld_q && ($signed(prev_q) < $signed(trigLevel))
                    && ($signed(sampleIn) >= $signed(trigLevel));
  assign auto_c   = trigAuto && (to_q >= TO_LIMIT);
  // {~s[7], s[6:0]} >> 1 : offset-binary, halved to 0..127
  assign conv_c   = {1'b0, ~sampleIn[7], sampleIn[6:1]};

  // State and datapath registers
  always_ff @(posedge ck100MHz or negedge rstLow) begin
    if (!rstLow) begin
      state_q    <= S_ARM;
      decim_q    <= '0;
      dcnt_q     <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      to_q       <= '0;
      widx_q     <= '0;
      hold_arm_q <= 1'b0;
      ena_q      <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      decim_q    <= decim_d;
      dcnt_q     <= dcnt_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      to_q       <= to_d;
      widx_q     <= widx_d;
      hold_arm_q <= hold_arm_d;
      ena_q      <= ena_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    decim_d    = decim_q;
    dcnt_d     = dcnt_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    to_d       = to_q;
    widx_d     = widx_q;
    hold_arm_d = 1'b0;
    ena_d      = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    done_d     = 1'b0;
    wr_c       = 1'b0;
    wr_idx_c   = widx_q;

    // Decimation counter only runs while armed or capturing
    if ((state_q == S_WAIT || state_q == S_CAPT) && sampleValid) begin
      dcnt_d = accept_c ? '0 : dcnt_q + CW'(1);
    end

    case (state_q)
      S_ARM: begin
        decim_d    = decim;
        dcnt_d     = '0;
        prev_vld_d = 1'b0;
        to_d       = '0;
        widx_d     = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (accept_c) begin
          prev_d     = sampleIn;
          prev_vld_d = 1'b1;
          to_d       = auto_c ? to_q : to_q + TW'(1);
          if (auto_c || cross_c) begin
            wr_c     = 1'b1;
            wr_idx_c = '0;
          end
        end
      end
      S_CAPT: begin
        if (accept_c) begin
          wr_c     = 1'b1;
          wr_idx_c = widx_q;
        end
      end
      S_HOLD: begin
        // Ignore a frameSync coinciding with the final write
        hold_arm_d = 1'b1;
        if (hold_arm_q && frameSync) begin
          state_d = S_ARM;
        end
      end
      default: state_d = S_ARM;
    endcase

    // One write per accepted sample; the last address closes the record
    if (wr_c) begin
      ena_d  = 1'b1;
      addr_d = wr_idx_c;
      din_d  = conv_c;
      widx_d = wr_idx_c + AW'(1);
      if (wr_idx_c == LAST_ADDR) begin
        done_d  = 1'b1;
        state_d = S_HOLD;
      end else begin
        state_d = S_CAPT;
      end
    end

    busy_d = (state_d == S_WAIT) || (state_d == S_CAPT);
  end

  assign enaTime     = ena_q;
  assign weaTime     = ena_q;
  assign addraTime   = addr_q;
  assign dinaTime    = din_q;
  assign captureBusy = busy_q;
  assign captureDone = done_q;

endmodule
